// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
//   pc_state_e : control FSM states (BOOT, RUN, HALT)
//   pc_sel_e   : next-PC source select
//   PC_STEP    : sequential fetch increment in bytes
package pc_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_TRAP,
        SEL_REDIR,
        SEL_HOLD,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular trace buffer of redirect PCs, built only with PC_TRACE_EN.
// Ports:
//   clk, reset_n : clock, async active-low reset (all entries cleared)
//   wr_en        : write strobe, stores wr_data and advances the write pointer
//   wr_data      : PC value to record
//   rd_idx       : read index, 0 = newest entry
//   rd_data      : combinational read of entry (wr_ptr-1-rd_idx) mod DEPTH
module pc_trace_buf
    import pc_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W-1:0]             rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_c;

    // Write port; pointer wraps naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
    end

    // Newest-relative read index.
    assign rd_ptr_c = wr_ptr_q - PTR_W'(1) - rd_idx;
    assign rd_data  = mem_q[rd_ptr_c];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: reset vector, +4 increment, branch/jump
// redirect, trap redirect, redirect alignment check, debug halt/resume FSM.
// Optional macro PC_TRACE_EN adds a ring buffer of redirect/trap target PCs.
// Ports:
//   clk, reset_n             : clock, async active-low reset
//   stall                    : hold PC
//   redirect, redirect_tgt   : taken branch/jump and its target
//   trap_req                 : go to TRAP_VECTOR
//   halt_req, resume         : debug halt / resume
//   pc_out, pc_valid         : registered fetch PC and its valid flag
//   misalign, misalign_addr  : one-cycle pulse and held offending target
//   trace_idx, trace_data    : trace read port (0 = newest); data is 0 without PC_TRACE_EN
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     ALIGN_BYTES  = 4,
    parameter int unsigned     TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic                           redirect,
    input  logic [XLEN-1:0]                redirect_tgt,
    input  logic                           trap_req,
    input  logic                           halt_req,
    input  logic                           resume,
    output logic [XLEN-1:0]                pc_out,
    output logic                           pc_valid,
    output logic                           misalign,
    output logic [XLEN-1:0]                misalign_addr,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_data
);

    pc_state_e       state_q, state_d;
    pc_sel_e         sel;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic            trace_we;
    logic            tgt_misaligned_c;

    assign tgt_misaligned_c = (redirect_tgt & XLEN'(ALIGN_BYTES - 1)) != '0;

    // Control FSM: state, next-PC source, valid and misalign updates.
    always_comb begin
        state_d         = state_q;
        sel             = SEL_HOLD;
        valid_d         = valid_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        trace_we        = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (trap_req) begin
                    sel      = SEL_TRAP;
                    trace_we = 1'b1;
                end else if (redirect) begin
                    trace_we = 1'b1;
                    if (tgt_misaligned_c) begin
                        sel             = SEL_TRAP;
                        misalign_d      = 1'b1;
                        misalign_addr_d = redirect_tgt;
                    end else begin
                        sel = SEL_REDIR;
                    end
                end else if (stall) begin
                    sel = SEL_HOLD;
                end else if (halt_req) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else begin
                    sel = SEL_INC;
                end
            end
            HALT: begin
                // A trap must not be lost, so it outranks resume here.
                if (trap_req) begin
                    state_d  = RUN;
                    valid_d  = 1'b1;
                    sel      = SEL_TRAP;
                    trace_we = 1'b1;
                end else if (resume) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Next-PC mux.
    always_comb begin
        unique case (sel)
            SEL_TRAP:  pc_d = TRAP_VECTOR;
            SEL_REDIR: pc_d = redirect_tgt;
            SEL_INC:   pc_d = pc_q + XLEN'(PC_STEP);
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= BOOT;
            pc_q            <= RESET_VECTOR;
            valid_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            valid_q         <= valid_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_valid      = valid_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

`ifdef PC_TRACE_EN
    pc_trace_buf #(
        .W     (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (trace_we),
        .wr_data (pc_d),
        .rd_idx  (trace_idx),
        .rd_data (trace_data)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_we, trace_idx};
    assign trace_data   = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, increment, stall, redirect-over-stall,
// misalignment (ALIGN_BYTES 4 and 2), halt/resume, wrap, trap priority,
// optional trace buffer, and reset in the middle of operation.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        trap_req;
    logic        halt_req;
    logic        resume;
    logic [2:0]  trace_idx;

    logic [31:0] pc_out;
    logic        pc_valid;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic [31:0] trace_data;

    logic [31:0] pc_out2;
    logic        pc_valid2;
    logic        misalign2;
    logic [31:0] unused_addr2;
    logic [31:0] unused_trace2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .ALIGN_BYTES(4), .TRACE_DEPTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_tgt  (redirect_tgt),
        .trap_req      (trap_req),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .trace_idx     (trace_idx),
        .trace_data    (trace_data)
    );

    pc_gen #(.XLEN(32), .ALIGN_BYTES(2), .TRACE_DEPTH(8)) dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_tgt  (redirect_tgt),
        .trap_req      (trap_req),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_out        (pc_out2),
        .pc_valid      (pc_valid2),
        .misalign      (misalign2),
        .misalign_addr (unused_addr2),
        .trace_idx     (trace_idx),
        .trace_data    (unused_trace2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_tgt = 32'h0;
        trap_req     = 1'b0;
        halt_req     = 1'b0;
        resume       = 1'b0;
        trace_idx    = 3'd0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        clear_in();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_pc got valid=%b pc=%h exp valid=0 pc=00000000", pc_valid, pc_out);
        end
        checks++;
        if ({misalign, misalign_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_misalign got %b/%h exp 0/00000000", misalign, misalign_addr);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc_valid, pc_out} !== {1'b1, exp_seq[i]}) begin
                errors++;
                $display("FAIL boot_seq[%0d] got valid=%b pc=%h exp valid=1 pc=%h", i, pc_valid, pc_out, exp_seq[i]);
            end
        end
        stall = 1'b1;
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL stall_hold got valid=%b pc=%h exp valid=1 pc=00000008", pc_valid, pc_out);
        end
        stall = 1'b0;
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, exp_seq[3]}) begin
            errors++;
            $display("FAIL after_stall got valid=%b pc=%h exp valid=1 pc=0000000c", pc_valid, pc_out);
        end
    endtask

    task automatic test_redirect_over_stall();
        redirect     = 1'b1;
        redirect_tgt = 32'h8;
        step();
        checks++;
        if (pc_out !== 32'h8) begin
            errors++;
            $display("FAIL redir_to_8 got %h exp 00000008", pc_out);
        end
        stall        = 1'b1;
        redirect_tgt = 32'h40;
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL redir_over_stall got valid=%b pc=%h exp valid=1 pc=00000040", pc_valid, pc_out);
        end
        clear_in();
        step();
        checks++;
        if (pc_out !== 32'h44) begin
            errors++;
            $display("FAIL redir_then_inc got %h exp 00000044", pc_out);
        end
    endtask

    task automatic test_misalign();
        redirect     = 1'b1;
        redirect_tgt = 32'h42;
        step();
        checks++;
        if ({pc_out, misalign, misalign_addr} !== {32'h100, 1'b1, 32'h42}) begin
            errors++;
            $display("FAIL misalign_a4 got pc=%h pulse=%b addr=%h exp pc=00000100 pulse=1 addr=00000042",
                     pc_out, misalign, misalign_addr);
        end
        checks++;
        if ({pc_out2, misalign2} !== {32'h42, 1'b0}) begin
            errors++;
            $display("FAIL aligned_a2 got pc=%h pulse=%b exp pc=00000042 pulse=0", pc_out2, misalign2);
        end
        clear_in();
        step();
        checks++;
        if ({pc_out, misalign, misalign_addr} !== {32'h104, 1'b0, 32'h42}) begin
            errors++;
            $display("FAIL misalign_after got pc=%h pulse=%b addr=%h exp pc=00000104 pulse=0 addr=00000042",
                     pc_out, misalign, misalign_addr);
        end
        checks++;
        if (pc_out2 !== 32'h46) begin
            errors++;
            $display("FAIL a2_after got %h exp 00000046", pc_out2);
        end
    endtask

    task automatic test_halt();
        redirect     = 1'b1;
        redirect_tgt = 32'h10;
        step();
        clear_in();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++;
        if ({pc_valid, pc_out} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL halt_enter got valid=%b pc=%h exp valid=0 pc=00000010", pc_valid, pc_out);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                redirect     = 1'b1;
                redirect_tgt = 32'h80;
                stall        = 1'b1;
            end
            if (i == 2) halt_req = 1'b1;
            step();
            clear_in();
            checks++;
            if ({pc_valid, pc_out} !== {1'b0, 32'h10}) begin
                errors++;
                $display("FAIL halt_hold[%0d] got valid=%b pc=%h exp valid=0 pc=00000010", i, pc_valid, pc_out);
            end
        end
        resume   = 1'b1;
        halt_req = 1'b1;
        step();
        clear_in();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL resume_refetch got valid=%b pc=%h exp valid=1 pc=00000010", pc_valid, pc_out);
        end
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h14}) begin
            errors++;
            $display("FAIL resume_inc got valid=%b pc=%h exp valid=1 pc=00000014", pc_valid, pc_out);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h18}) begin
            errors++;
            $display("FAIL resume_in_run got valid=%b pc=%h exp valid=1 pc=00000018", pc_valid, pc_out);
        end
    endtask

    task automatic test_wrap_trap();
        redirect     = 1'b1;
        redirect_tgt = 32'hFFFF_FFFC;
        step();
        clear_in();
        checks++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL redir_top got %h exp fffffffc", pc_out);
        end
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap got valid=%b pc=%h exp valid=1 pc=00000000", pc_valid, pc_out);
        end
        trap_req     = 1'b1;
        redirect     = 1'b1;
        redirect_tgt = 32'h40;
        step();
        checks++;
        if (pc_out !== 32'h100) begin
            errors++;
            $display("FAIL trap_over_redir got %h exp 00000100", pc_out);
        end
        redirect_tgt = 32'h42;
        step();
        clear_in();
        checks++;
        if ({pc_out, misalign} !== {32'h100, 1'b0}) begin
            errors++;
            $display("FAIL trap_misaligned_tgt got pc=%h pulse=%b exp pc=00000100 pulse=0", pc_out, misalign);
        end
        step();
        halt_req = 1'b1;
        step();
        clear_in();
        checks++;
        if ({pc_valid, pc_out} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL halt_at_104 got valid=%b pc=%h exp valid=0 pc=00000104", pc_valid, pc_out);
        end
        trap_req = 1'b1;
        step();
        clear_in();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL trap_in_halt got valid=%b pc=%h exp valid=1 pc=00000100", pc_valid, pc_out);
        end
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL trap_halt_inc got valid=%b pc=%h exp valid=1 pc=00000104", pc_valid, pc_out);
        end
    endtask

    task automatic test_trace();
`ifdef PC_TRACE_EN
        for (int k = 1; k <= 10; k++) begin
            redirect     = 1'b1;
            redirect_tgt = 32'(k * 16);
            step();
            checks++;
            if (pc_out !== 32'(k * 16)) begin
                errors++;
                $display("FAIL trace_redir[%0d] got %h exp %h", k, pc_out, 32'(k * 16));
            end
        end
        clear_in();
        trace_idx = 3'd0;
        #1;
        checks++;
        if (trace_data !== 32'hA0) begin
            errors++;
            $display("FAIL trace_idx0 got %h exp 000000a0", trace_data);
        end
        trace_idx = 3'd7;
        #1;
        checks++;
        if (trace_data !== 32'h30) begin
            errors++;
            $display("FAIL trace_idx7 got %h exp 00000030", trace_data);
        end
        trace_idx = 3'd1;
        #1;
        checks++;
        if (trace_data !== 32'h90) begin
            errors++;
            $display("FAIL trace_idx1 got %h exp 00000090", trace_data);
        end
        trace_idx = 3'd0;
`else
        trace_idx = 3'd5;
        #1;
        checks++;
        if (trace_data !== 32'h0) begin
            errors++;
            $display("FAIL trace_tied got %h exp 00000000", trace_data);
        end
        trace_idx = 3'd0;
`endif
    endtask

    task automatic test_reset_mid();
        redirect     = 1'b1;
        redirect_tgt = 32'h200;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pc_valid, pc_out, misalign, misalign_addr} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset got valid=%b pc=%h pulse=%b addr=%h exp valid=0 pc=00000000 pulse=0 addr=00000000",
                     pc_valid, pc_out, misalign, misalign_addr);
        end
`ifdef PC_TRACE_EN
        checks++;
        if (trace_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_trace got %h exp 00000000", trace_data);
        end
`endif
        step();
        step();
        clear_in();
        reset_n = 1'b1;
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rereset_boot got valid=%b pc=%h exp valid=1 pc=00000000", pc_valid, pc_out);
        end
        step();
        checks++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL rereset_inc got valid=%b pc=%h exp valid=1 pc=00000004", pc_valid, pc_out);
        end
    endtask

    initial begin
        test_reset();
        test_redirect_over_stall();
        test_misalign();
        test_halt();
        test_wrap_trap();
        test_trace();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
